// File: rtl/vga_frame_scanner.sv
// vga_frame_scanner: raster timing generator plus 256x256 grayscale framebuffer fetch.
// Pipeline: stage 0 raster counters, stage 1 address/flag register, stage 2 registered outputs.
// Sync and pixel data leave the block co-aligned, two cycles behind the counters.
module vga_frame_scanner #(
  parameter int unsigned H_VIS  = 640,
  parameter int unsigned H_FP   = 16,
  parameter int unsigned H_SYNC = 96,
  parameter int unsigned H_BP   = 48,
  parameter int unsigned V_VIS  = 480,
  parameter int unsigned V_FP   = 10,
  parameter int unsigned V_SYNC = 2,
  parameter int unsigned V_BP   = 33
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        image_select,
  output logic [16:0] mem_addr,
  input  logic [7:0]  mem_data,
  output logic        hsync,
  output logic        vsync,
  output logic [23:0] rgb_out,
  output logic        frame_start
);

  // Counter width covers line/frame totals up to 1024.
  localparam int unsigned CNT_W   = 10;
  localparam int unsigned IMG_DIM = 256;
  localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS_END = CNT_W'(H_VIS);
  localparam logic [CNT_W-1:0] V_VIS_END = CNT_W'(V_VIS);
  localparam logic [CNT_W-1:0] H_SYNC_LO = CNT_W'(H_VIS + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_HI = CNT_W'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] V_SYNC_LO = CNT_W'(V_VIS + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_HI = CNT_W'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [CNT_W-1:0] IMG_END   = CNT_W'(IMG_DIM);

  // Stage 0 state
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             slot;

  // Stage 0 decode
  logic h_last_c;
  logic v_last_c;
  logic in_img_c;
  logic hs_raw_c;
  logic vs_raw_c;
  logic first_c;

  // Stage 1 flags travelling alongside mem_addr
  logic in_img_d;
  logic hs_d;
  logic vs_d;
  logic first_d;

  // Decode raster position into region, sync and frame-origin flags.
  always_comb begin
    h_last_c = 1'b0;
    v_last_c = 1'b0;
    in_img_c = 1'b0;
    hs_raw_c = 1'b1;
    vs_raw_c = 1'b1;
    first_c  = 1'b0;

    h_last_c = (h_cnt == H_LAST);
    v_last_c = (v_cnt == V_LAST);
    // Image pixels are only shown where the screen is also visible.
    in_img_c = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END) &&
               (h_cnt < IMG_END)   && (v_cnt < IMG_END);
    hs_raw_c = !((h_cnt >= H_SYNC_LO) && (h_cnt <= H_SYNC_HI));
    vs_raw_c = !((v_cnt >= V_SYNC_LO) && (v_cnt <= V_SYNC_HI));
    first_c  = (h_cnt == '0) && (v_cnt == '0);
  end

  // Raster counters: pixel counter wraps each line, line counter wraps each frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last_c) begin
      h_cnt <= '0;
      v_cnt <= v_last_c ? '0 : v_cnt + CNT_W'(1);
    end else begin
      h_cnt <= h_cnt + CNT_W'(1);
    end
  end

  // Image slot only changes on the last pixel of a frame so a frame never mixes slots.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot <= 1'b0;
    end else if (h_last_c && v_last_c) begin
      slot <= image_select;
    end
  end

  // Stage 1: issue framebuffer read inside the image, register flags alongside.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr <= '0;
      in_img_d <= 1'b0;
      hs_d     <= 1'b1;
      vs_d     <= 1'b1;
      first_d  <= 1'b0;
    end else begin
      if (in_img_c) begin
        mem_addr <= {slot, v_cnt[7:0], h_cnt[7:0]};
      end
      in_img_d <= in_img_c;
      hs_d     <= hs_raw_c;
      vs_d     <= vs_raw_c;
      first_d  <= first_c;
    end
  end

  // Stage 2: replicate grayscale onto all channels; black outside the image.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_out     <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      rgb_out     <= in_img_d ? {mem_data, mem_data, mem_data} : 24'h0;
      hsync       <= hs_d;
      vsync       <= vs_d;
      frame_start <= first_d;
    end
  end

endmodule

// File: tb/tb_vga_frame_scanner.sv
// tb_vga_frame_scanner: three scaled-timing instances checked against a raster-position model.
// Instance 0 has short lines/frames, instance 1 is wider than the image, instance 2 is taller.
module tb_vga_frame_scanner;

  localparam int A_HV = 24,  A_HF = 4, A_HS = 6, A_HB = 6;
  localparam int A_VV = 12,  A_VF = 2, A_VS = 2, A_VB = 4;
  localparam int B_HV = 264, B_HF = 2, B_HS = 4, B_HB = 2;
  localparam int B_VV = 4,   B_VF = 1, B_VS = 1, B_VB = 2;
  localparam int C_HV = 6,   C_HF = 2, C_HS = 4, C_HB = 4;
  localparam int C_VV = 260, C_VF = 1, C_VS = 2, C_VB = 1;

  logic        clk;
  logic        rst  [3];
  logic        sel  [3];
  logic [16:0] addr [3];
  logic [7:0]  mdat [3];
  logic        hs   [3];
  logic        vs   [3];
  logic        fs   [3];
  logic [23:0] rgb  [3];
  int          mode [3];

  int p_hv[3], p_hf[3], p_hs[3], p_ht[3];
  int p_vv[3], p_vf[3], p_vs[3], p_vt[3];

  int          total;
  int          bad;
  int          gcnt;
  int          nedge     [3];
  bit          slot_f    [3][64];
  logic [16:0] last_addr [3];
  int          fs_last   [3];
  int          hfall     [3];
  int          vlow      [3];
  logic        prev_hs   [3];
  logic        prev_vs   [3];

  // Framebuffer contents: 0 = low address byte, 1 = all white, else address hash.
  function automatic logic [7:0] ram(input int md, input logic [16:0] a);
    int v;
    v = int'(a);
    case (md)
      0:       return a[7:0];
      1:       return 8'hFF;
      default: return 8'((v * 37) ^ (v >> 6) ^ 32'h5A);
    endcase
  endfunction

  assign mdat[0] = ram(mode[0], addr[0]);
  assign mdat[1] = ram(mode[1], addr[1]);
  assign mdat[2] = ram(mode[2], addr[2]);

  vga_frame_scanner #(.H_VIS(A_HV), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
                      .V_VIS(A_VV), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB)) dut_a (
    .clk(clk), .reset(rst[0]), .image_select(sel[0]), .mem_addr(addr[0]), .mem_data(mdat[0]),
    .hsync(hs[0]), .vsync(vs[0]), .rgb_out(rgb[0]), .frame_start(fs[0]));

  vga_frame_scanner #(.H_VIS(B_HV), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
                      .V_VIS(B_VV), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB)) dut_b (
    .clk(clk), .reset(rst[1]), .image_select(sel[1]), .mem_addr(addr[1]), .mem_data(mdat[1]),
    .hsync(hs[1]), .vsync(vs[1]), .rgb_out(rgb[1]), .frame_start(fs[1]));

  vga_frame_scanner #(.H_VIS(C_HV), .H_FP(C_HF), .H_SYNC(C_HS), .H_BP(C_HB),
                      .V_VIS(C_VV), .V_FP(C_VF), .V_SYNC(C_VS), .V_BP(C_VB)) dut_c (
    .clk(clk), .reset(rst[2]), .image_select(sel[2]), .mem_addr(addr[2]), .mem_data(mdat[2]),
    .hsync(hs[2]), .vsync(vs[2]), .rgb_out(rgb[2]), .frame_start(fs[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int i, input logic [23:0] obs, input logic [23:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s inst=%0d edge=%0d observed=%h expected=%h", tag, i, nedge[i], obs, exp);
    end
  endtask

  function automatic logic img(input int i, input int x, input int y);
    return (x < p_hv[i]) && (y < p_vv[i]) && (x < 256) && (y < 256);
  endfunction

  task automatic model_reset(input int i);
    nedge[i]     = 0;
    slot_f[i][0] = 1'b0;
    last_addr[i] = '0;
    fs_last[i]   = -1;
    hfall[i]     = 0;
    vlow[i]      = 0;
    prev_hs[i]   = 1'b1;
    prev_vs[i]   = 1'b1;
  endtask

  // One clock edge seen from raster position nedge (edges since reset release).
  task automatic model_edge(input int i);
    int ft, x, y;
    ft = p_ht[i] * p_vt[i];
    if ((nedge[i] % ft) == ft - 1)
      slot_f[i][((nedge[i] / ft) + 1) % 64] = sel[i];
    x = nedge[i] % p_ht[i];
    y = (nedge[i] / p_ht[i]) % p_vt[i];
    if (img(i, x, y))
      last_addr[i] = {slot_f[i][(nedge[i] / ft) % 64], 8'(y), 8'(x)};
    nedge[i]++;
  endtask

  task automatic check_inst(input int i);
    int ft, p, x, y, f;
    logic [23:0] e_rgb;
    logic [7:0]  pix;
    logic        e_hs, e_vs, e_fs;
    ft    = p_ht[i] * p_vt[i];
    e_hs  = 1'b1;
    e_vs  = 1'b1;
    e_fs  = 1'b0;
    e_rgb = '0;
    if (nedge[i] >= 2) begin
      p    = nedge[i] - 2;
      x    = p % p_ht[i];
      y    = (p / p_ht[i]) % p_vt[i];
      f    = p / ft;
      e_hs = !((x >= p_hv[i] + p_hf[i]) && (x < p_hv[i] + p_hf[i] + p_hs[i]));
      e_vs = !((y >= p_vv[i] + p_vf[i]) && (y < p_vv[i] + p_vf[i] + p_vs[i]));
      e_fs = (x == 0) && (y == 0);
      if (img(i, x, y)) begin
        pix   = ram(mode[i], {slot_f[i][f % 64], 8'(y), 8'(x)});
        e_rgb = {pix, pix, pix};
      end
    end
    chk("hsync", i, 24'(hs[i]), 24'(e_hs));
    chk("vsync", i, 24'(vs[i]), 24'(e_vs));
    chk("frame_start", i, 24'(fs[i]), 24'(e_fs));
    chk("rgb_out", i, rgb[i], e_rgb);
    chk("mem_addr", i, 24'(addr[i]), 24'(last_addr[i]));
    // Whole-frame properties measured from the observed waveform.
    if (nedge[i] > 0) begin
      if (prev_hs[i] === 1'b1 && hs[i] === 1'b0) hfall[i]++;
      if (vs[i] === 1'b0) vlow[i]++;
      else if (prev_vs[i] === 1'b0) begin
        chk("vsync_low_len", i, 24'(vlow[i]), 24'(p_vs[i] * p_ht[i]));
        vlow[i] = 0;
      end
      if (fs[i] === 1'b1) begin
        if (fs_last[i] < 0) chk("first_fs_latency", i, 24'(nedge[i]), 24'(2));
        else begin
          chk("fs_period", i, 24'(gcnt - fs_last[i]), 24'(ft));
          chk("hsync_falls", i, 24'(hfall[i]), 24'(p_vt[i]));
        end
        hfall[i]   = 0;
        fs_last[i] = gcnt;
      end
      prev_hs[i] = hs[i];
      prev_vs[i] = vs[i];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    gcnt++;
    for (int i = 0; i < 3; i++) if (!rst[i]) model_edge(i);
    #1;
    for (int i = 0; i < 3; i++) check_inst(i);
  endtask

  // Reset pulse placed between clock edges; outputs must clear at once.
  task automatic async_reset(input int i, input int cycles);
    #2;
    rst[i] = 1'b1;
    model_reset(i);
    #1;
    check_inst(i);
    repeat (cycles) tick();
    #2;
    rst[i] = 1'b0;
  endtask

  initial begin
    int ri;
    p_hv = '{A_HV, B_HV, C_HV};
    p_hf = '{A_HF, B_HF, C_HF};
    p_hs = '{A_HS, B_HS, C_HS};
    p_ht = '{A_HV + A_HF + A_HS + A_HB, B_HV + B_HF + B_HS + B_HB, C_HV + C_HF + C_HS + C_HB};
    p_vv = '{A_VV, B_VV, C_VV};
    p_vf = '{A_VF, B_VF, C_VF};
    p_vs = '{A_VS, B_VS, C_VS};
    p_vt = '{A_VV + A_VF + A_VS + A_VB, B_VV + B_VF + B_VS + B_VB, C_VV + C_VF + C_VS + C_VB};
    total = 0;
    bad   = 0;
    gcnt  = 0;
    for (int i = 0; i < 3; i++) begin
      rst[i]  = 1'b1;
      sel[i]  = 1'b0;
      mode[i] = 0;
      model_reset(i);
    end

    // Held in reset: all outputs at reset values.
    repeat (3) tick();
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;

    // Address-pattern data; instance 0 selects slot 1 from its second frame on.
    sel[0] = 1'b1;
    repeat (3000) tick();

    // All-white data with occasional mid-frame select toggles.
    for (int i = 0; i < 3; i++) mode[i] = 1;
    repeat (3000) begin
      tick();
      for (int i = 0; i < 3; i++)
        if ($urandom_range(0, 99) == 0) sel[i] = ~sel[i];
    end

    // Hashed data with a random select every cycle.
    for (int i = 0; i < 3; i++) mode[i] = 2;
    repeat (6000) begin
      tick();
      for (int i = 0; i < 3; i++) sel[i] = 1'($urandom_range(0, 1));
    end

    // Mid-frame asynchronous resets at random positions.
    repeat (12) begin
      repeat ($urandom_range(50, 900)) begin
        tick();
        for (int i = 0; i < 3; i++) sel[i] = 1'($urandom_range(0, 1));
      end
      ri = $urandom_range(0, 1);
      mode[ri] = $urandom_range(0, 2);
      async_reset(ri, 3);
    end
    async_reset(2, 3);
    repeat (2400) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
